// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: FSM states, ALU ops,
// datapath mux selects and the opcode/funct constants from mips.h.
package mips_ctrl_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned OPC_W    = 6;
   localparam int unsigned FUNCT_W  = 6;
   localparam int unsigned ALU_OP_W = 3;
   localparam int unsigned SEL_W    = 2;
   localparam int unsigned CNT_W    = 32;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      EXEC_R   = 4'd2,
      ALU_WB   = 4'd3,
      EXEC_I   = 4'd4,
      IMM_WB   = 4'd5,
      MEM_ADDR = 4'd6,
      MEM_RD   = 4'd7,
      MEM_WB   = 4'd8,
      MEM_WR   = 4'd9,
      BRANCH   = 4'd10,
      JUMP     = 4'd11,
      HALT     = 4'd12
   } state_t;

   localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b111;

   localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [SEL_W-1:0] REG_DST_RT = 2'b00;
   localparam logic [SEL_W-1:0] REG_DST_RD = 2'b01;
   localparam logic [SEL_W-1:0] REG_DST_RA = 2'b10;

   localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
   localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
   localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

   localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
   localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
   localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
   localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [OPC_W-1:0] OP_SPECIAL = 6'h00;
   localparam logic [OPC_W-1:0] OP_J       = 6'h02;
   localparam logic [OPC_W-1:0] OP_JAL     = 6'h03;
   localparam logic [OPC_W-1:0] OP_BEQ     = 6'h04;
   localparam logic [OPC_W-1:0] OP_BNE     = 6'h05;
   localparam logic [OPC_W-1:0] OP_ADDI    = 6'h08;
   localparam logic [OPC_W-1:0] OP_ORI     = 6'h0D;
   localparam logic [OPC_W-1:0] OP_LW      = 6'h23;
   localparam logic [OPC_W-1:0] OP_SW      = 6'h2B;

   localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
   localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
   localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
   localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
   localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/multicycle_control_alu_op_decode.sv
// alu_op_decode: maps opcode/funct to the 3-bit ALU op and flags whether the
// encoding is one the control FSM supports.
module alu_op_decode
   import mips_ctrl_pkg::*;
(
   input  logic [OPC_W-1:0]    opcode,
   input  logic [FUNCT_W-1:0]  funct,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                legal
);

   always_comb begin
      alu_op = ALU_ADD;
      legal  = 1'b0;
      case (opcode)
         OP_SPECIAL: begin
            legal = 1'b1;
            case (funct)
               FN_ADD:  alu_op = ALU_ADD;
               FN_SUB:  alu_op = ALU_SUB;
               FN_AND:  alu_op = ALU_AND;
               FN_OR:   alu_op = ALU_OR;
               FN_SLT:  alu_op = ALU_SLT;
               default: legal  = 1'b0;
            endcase
         end
         OP_LW, OP_SW, OP_ADDI: legal = 1'b1;
         OP_ORI: begin
            legal  = 1'b1;
            alu_op = ALU_OR;
         end
         OP_BEQ, OP_BNE: begin
            legal  = 1'b1;
            alu_op = ALU_SUB;
         end
         OP_J, OP_JAL: legal = 1'b1;
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM sequencing the shared MIPS datapath.
// Optional MC_PERF_CNT_EN adds cycle_cnt / retire_cnt performance counters.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter state_t RESET_STATE  = FETCH,
   parameter bit     HALT_ON_ZERO = 1'b1
)
(
   input  logic                clock,
   input  logic                reset,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic [SEL_W-1:0]    pc_src,
   output logic                ir_write,
   output logic                i_or_d,
   output logic                mem_read,
   output logic                mem_write,
   output logic                reg_write,
   output logic [SEL_W-1:0]    reg_dst,
   output logic [SEL_W-1:0]    mem_to_reg,
   output logic                alu_src_a,
   output logic [SEL_W-1:0]    alu_src_b,
   output logic                zero_ext,
   output logic [ALU_OP_W-1:0] alu_op,
   output logic                halted,
   output logic                illegal
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    retire_cnt
`endif
);

   state_t                state;
   state_t                next_state;
   logic                  set_illegal;
   logic [OPC_W-1:0]      opcode;
   logic [FUNCT_W-1:0]    funct;
   logic [ALU_OP_W-1:0]   dec_alu_op;
   logic                  dec_legal;

   assign opcode = instr[31:26];
   assign funct  = instr[5:0];

   alu_op_decode u_alu_op_decode (
      .opcode (opcode),
      .funct  (funct),
      .alu_op (dec_alu_op),
      .legal  (dec_legal)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= RESET_STATE;
      end else begin
         state <= next_state;
      end
   end

   // Sticky cause flag for HALT: set only when DECODE rejects an encoding.
   always_ff @(posedge clock) begin
      if (reset) begin
         illegal <= 1'b0;
      end else if (set_illegal) begin
         illegal <= 1'b1;
      end
   end

   always_comb begin
      next_state  = state;
      set_illegal = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_SRC_ALU;
      ir_write    = 1'b0;
      i_or_d      = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = REG_DST_RT;
      mem_to_reg  = M2R_ALUOUT;
      alu_src_a   = 1'b0;
      alu_src_b   = SRCB_REG;
      zero_ext    = 1'b0;
      alu_op      = ALU_AND;
      halted      = 1'b0;

      case (state)
         FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = SRCB_FOUR;
            alu_op    = ALU_ADD;
            if (mem_ready) begin
               ir_write   = 1'b1;
               pc_write   = 1'b1;
               next_state = DECODE;
            end
         end
         DECODE: begin
            // ALU forms PC + (imm << 2) so BRANCH finds its target in ALUOut.
            alu_src_b = SRCB_IMM_SH;
            alu_op    = ALU_ADD;
            if (HALT_ON_ZERO && (instr == INSTR_W'(0))) begin
               next_state = HALT;
            end else if (!dec_legal) begin
               next_state  = HALT;
               set_illegal = 1'b1;
            end else begin
               case (opcode)
                  OP_SPECIAL:     next_state = EXEC_R;
                  OP_LW, OP_SW:   next_state = MEM_ADDR;
                  OP_ADDI, OP_ORI: next_state = EXEC_I;
                  OP_BEQ, OP_BNE: next_state = BRANCH;
                  OP_J, OP_JAL:   next_state = JUMP;
                  default: begin
                     next_state  = HALT;
                     set_illegal = 1'b1;
                  end
               endcase
            end
         end
         EXEC_R: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_REG;
            alu_op     = dec_alu_op;
            next_state = ALU_WB;
         end
         ALU_WB: begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RD;
            mem_to_reg = M2R_ALUOUT;
            next_state = FETCH;
         end
         EXEC_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_op     = dec_alu_op;
            zero_ext   = (opcode == OP_ORI);
            next_state = IMM_WB;
         end
         IMM_WB: begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RT;
            mem_to_reg = M2R_ALUOUT;
            next_state = FETCH;
         end
         MEM_ADDR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_op     = ALU_ADD;
            next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
         end
         MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
            if (mem_ready) begin
               next_state = MEM_WB;
            end
         end
         MEM_WB: begin
            reg_write  = 1'b1;
            reg_dst    = REG_DST_RT;
            mem_to_reg = M2R_MDR;
            next_state = FETCH;
         end
         MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (mem_ready) begin
               next_state = FETCH;
            end
         end
         BRANCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_REG;
            alu_op     = ALU_SUB;
            pc_src     = PC_SRC_ALUOUT;
            pc_write   = (opcode == OP_BNE) ? ~zero : zero;
            next_state = FETCH;
         end
         JUMP: begin
            pc_src   = PC_SRC_JUMP;
            pc_write = 1'b1;
            // PC already holds PC+4 here, which is the JAL link value.
            if (opcode == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = REG_DST_RA;
               mem_to_reg = M2R_PC;
            end
            next_state = FETCH;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: begin
            next_state = HALT;
         end
      endcase

      // A reset cycle aborts the current instruction: present FETCH's static
      // selects and suppress every write enable and side effect.
      if (reset) begin
         set_illegal = 1'b0;
         pc_write    = 1'b0;
         pc_src      = PC_SRC_ALU;
         ir_write    = 1'b0;
         i_or_d      = 1'b0;
         mem_read    = 1'b1;
         mem_write   = 1'b0;
         reg_write   = 1'b0;
         reg_dst     = REG_DST_RT;
         mem_to_reg  = M2R_ALUOUT;
         alu_src_a   = 1'b0;
         alu_src_b   = SRCB_FOUR;
         zero_ext    = 1'b0;
         alu_op      = ALU_ADD;
         halted      = 1'b0;
      end
   end

`ifdef MC_PERF_CNT_EN
   // An instruction retires on any entry into FETCH from another state.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (state != HALT) begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
         end
         if ((state != FETCH) && (next_state == FETCH)) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
         end
      end
   end
`else
   // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control; expected control vectors are
// hand-derived per state. Checks counters when MC_PERF_CNT_EN is defined.
module tb_multicycle_control;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        zero;
   logic        mem_ready;
   logic        pc_write;
   logic [1:0]  pc_src;
   logic        ir_write;
   logic        i_or_d;
   logic        mem_read;
   logic        mem_write;
   logic        reg_write;
   logic [1:0]  reg_dst;
   logic [1:0]  mem_to_reg;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic        zero_ext;
   logic [2:0]  alu_op;
   logic        halted;
   logic        illegal;
`ifdef MC_PERF_CNT_EN
   logic [31:0] cycle_cnt;
   logic [31:0] retire_cnt;
`endif

   int tests  = 0;
   int failed = 0;

   always #5 clock = ~clock;

   multicycle_control dut (
      .clock      (clock),
      .reset      (reset),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .ir_write   (ir_write),
      .i_or_d     (i_or_d),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .zero_ext   (zero_ext),
      .alu_op     (alu_op),
      .halted     (halted),
      .illegal    (illegal)
`ifdef MC_PERF_CNT_EN
      ,
      .cycle_cnt  (cycle_cnt),
      .retire_cnt (retire_cnt)
`endif
   );

   // {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
   //  reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op, halted, illegal}
   logic [20:0] ctrl;
   assign ctrl = {pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write, reg_write,
                  reg_dst, mem_to_reg, alu_src_a, alu_src_b, zero_ext, alu_op, halted, illegal};

   localparam logic [20:0] E_IDLE     = {1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,3'b010,1'b0,1'b0};
   localparam logic [20:0] E_FETCH    = {1'b1,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,3'b010,1'b0,1'b0};
   localparam logic [20:0] E_DECODE   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,3'b010,1'b0,1'b0};
   localparam logic [20:0] E_EXEC_ADD = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,3'b010,1'b0,1'b0};
   localparam logic [20:0] E_ALU_WB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,2'b00,1'b0,3'b000,1'b0,1'b0};
   localparam logic [20:0] E_MEM_ADDR = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,3'b010,1'b0,1'b0};
   localparam logic [20:0] E_MEM_RD   = {1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,3'b000,1'b0,1'b0};
   localparam logic [20:0] E_MEM_WB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0,2'b00,1'b0,3'b000,1'b0,1'b0};
   localparam logic [20:0] E_BEQ_TK   = {1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,3'b110,1'b0,1'b0};
   localparam logic [20:0] E_BNE_NT   = {1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b00,1'b0,3'b110,1'b0,1'b0};
   localparam logic [20:0] E_JAL      = {1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b10,1'b0,2'b00,1'b0,3'b000,1'b0,1'b0};
   localparam logic [20:0] E_EXEC_ORI = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b1,3'b001,1'b0,1'b0};
   localparam logic [20:0] E_IMM_WB   = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b00,1'b0,3'b000,1'b0,1'b0};
   localparam logic [20:0] E_MEM_WR   = {1'b0,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,3'b000,1'b0,1'b0};
   localparam logic [20:0] E_HALT_ILL = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,3'b000,1'b1,1'b1};
   localparam logic [20:0] E_HALT     = {1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,3'b000,1'b1,1'b0};

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset     = 1'b1;
      instr     = 32'h0109_5020;   // add $10,$8,$9
      zero      = 1'b0;
      mem_ready = 1'b1;

      cyc(); chk("rst_hold1", 32'(ctrl), 32'(E_IDLE));
      cyc(); chk("rst_hold2", 32'(ctrl), 32'(E_IDLE));
      reset = 1'b0; #1;
      chk("add_fetch", 32'(ctrl), 32'(E_FETCH));
`ifdef MC_PERF_CNT_EN
      chk("cnt_start_cycle", cycle_cnt, 32'd0);
      chk("cnt_start_retire", retire_cnt, 32'd0);
`endif
      cyc(); chk("add_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("add_exec", 32'(ctrl), 32'(E_EXEC_ADD));
      cyc(); chk("add_wb", 32'(ctrl), 32'(E_ALU_WB));

      // LW with two wait cycles in MEM_RD
      cyc(); instr = 32'h8D09_0004; #1;
      chk("add_back_fetch", 32'(ctrl), 32'(E_FETCH));
      cyc(); chk("lw_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("lw_addr", 32'(ctrl), 32'(E_MEM_ADDR));
      cyc(); mem_ready = 1'b0; #1;
      chk("lw_rd1", 32'(ctrl), 32'(E_MEM_RD));
      cyc(); chk("lw_rd2", 32'(ctrl), 32'(E_MEM_RD));
      cyc(); mem_ready = 1'b1; #1;
      chk("lw_rd3", 32'(ctrl), 32'(E_MEM_RD));
      cyc(); chk("lw_wb", 32'(ctrl), 32'(E_MEM_WB));

      // BEQ taken, then BNE not taken, both with zero=1
      cyc(); instr = 32'h1022_0003; zero = 1'b1; #1;
      chk("lw_done_fetch", 32'(ctrl), 32'(E_FETCH));
      cyc(); chk("beq_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("beq_branch", 32'(ctrl), 32'(E_BEQ_TK));
      cyc(); instr = 32'h1422_0003; #1;
      chk("beq_done_fetch", 32'(ctrl), 32'(E_FETCH));
      cyc(); chk("bne_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("bne_branch", 32'(ctrl), 32'(E_BNE_NT));

      cyc(); instr = 32'h0C10_0004; zero = 1'b0; #1;
      chk("bne_done_fetch", 32'(ctrl), 32'(E_FETCH));
      cyc(); chk("jal_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("jal_jump", 32'(ctrl), 32'(E_JAL));

      cyc(); instr = 32'h3508_000F; #1;
      chk("jal_done_fetch", 32'(ctrl), 32'(E_FETCH));
      cyc(); chk("ori_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("ori_exec", 32'(ctrl), 32'(E_EXEC_ORI));
      cyc(); chk("ori_wb", 32'(ctrl), 32'(E_IMM_WB));

      // SW stalled in MEM_WR, then aborted by reset
      cyc(); instr = 32'hAD09_0004; #1;
      chk("ori_done_fetch", 32'(ctrl), 32'(E_FETCH));
`ifdef MC_PERF_CNT_EN
      chk("cnt_cycle_24", cycle_cnt, 32'd24);
      chk("cnt_retire_6", retire_cnt, 32'd6);
`endif
      cyc(); chk("sw_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("sw_addr", 32'(ctrl), 32'(E_MEM_ADDR));
      cyc(); mem_ready = 1'b0; #1;
      chk("sw_wr", 32'(ctrl), 32'(E_MEM_WR));
      reset = 1'b1; #1;
      chk("sw_rst_cycle", 32'(ctrl), 32'(E_IDLE));
      chk("sw_rst_mem_write", 32'(mem_write), 32'd0);
      cyc(); reset = 1'b0; mem_ready = 1'b1; instr = 32'hFC00_0000; #1;
      chk("sw_rst_fetch", 32'(ctrl), 32'(E_FETCH));
`ifdef MC_PERF_CNT_EN
      chk("cnt_rst_cycle", cycle_cnt, 32'd0);
      chk("cnt_rst_retire", retire_cnt, 32'd0);
`endif

      // Unsupported opcode halts with illegal set
      cyc(); chk("ill_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("ill_halt", 32'(ctrl), 32'(E_HALT_ILL));
      cyc(); cyc();
      chk("ill_halt_hold", 32'(ctrl), 32'(E_HALT_ILL));
`ifdef MC_PERF_CNT_EN
      chk("cnt_halt_cycle", cycle_cnt, 32'd2);
      chk("cnt_halt_retire", retire_cnt, 32'd0);
`endif

      // All-zero word halts without illegal
      reset = 1'b1;
      cyc(); reset = 1'b0; instr = 32'h0000_0000; #1;
      chk("z_fetch", 32'(ctrl), 32'(E_FETCH));
      cyc(); chk("z_decode", 32'(ctrl), 32'(E_DECODE));
      cyc(); chk("z_halt", 32'(ctrl), 32'(E_HALT));
      cyc(); chk("z_halt_hold", 32'(ctrl), 32'(E_HALT));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath: PC register, unified instruction/data memory, register file, and one ALU.
- Replaces per-instruction combinational decode. Each instruction is broken into FETCH/DECODE/EXECUTE/MEM/WB steps, so a single ALU and a single memory port are shared across cycles.
- Sits between the instruction register (IR) and datapath mux/enable inputs. Waits on a memory-ready handshake.

Parameters:
- RESET_STATE, 0 (FETCH), state entered on reset.
- HALT_ON_ZERO, 1, all-zero instruction word sends the FSM to HALT.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous reset
- instr  in  32  current IR contents; opcode = [31:26], funct = [5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepted/completed the current access this cycle
- pc_write  out  1  load PC
- pc_src  out  2  00 ALU result, 01 ALUOut reg (branch target), 10 jump address
- ir_write  out  1  load IR
- i_or_d  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- reg_write  out  1  register-file write enable
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  2  00 ALUOut, 01 MDR, 10 PC (link)
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- zero_ext  out  1  immediate zero-extended (ORI)
- alu_op  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- halted  out  1  FSM in HALT
- illegal  out  1  HALT was entered due to an unsupported encoding

Behaviour:
- Reset (synchronous):
  - state = FETCH.
  - illegal = 0.
  - All outputs are 0 except those FETCH itself drives.
  - Reset asserted mid-instruction aborts it; no reg_write or mem_write occurs in the reset cycle.
- Outputs are Moore (decoded from state). Exceptions: pc_write in FETCH, BRANCH and JUMP, as defined below.
- FETCH:
  - Drives i_or_d=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=010, pc_src=00.
  - Holds while mem_ready=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 in that same cycle, then go to DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=010, so the branch target is captured in ALUOut.
  - If instr==0 and HALT_ON_ZERO: go to HALT.
  - Otherwise dispatch on opcode:
    - SPECIAL 00 -> EXEC_R, only if funct ∈ {20 ADD, 22 SUB, 24 AND, 25 OR, 2A SLT}; any other funct -> HALT with illegal=1.
    - LW 23 or SW 2B -> MEM_ADDR.
    - ADDI 08 or ORI 0D -> EXEC_I.
    - BEQ 04 or BNE 05 -> BRANCH.
    - J 02 or JAL 03 -> JUMP.
    - Any other opcode -> HALT with illegal=1.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct. Next ALU_WB.
- ALU_WB: reg_write=1, reg_dst=01, mem_to_reg=00. Next FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10.
  - ADDI: alu_op=010.
  - ORI: alu_op=001, zero_ext=1.
  - Next IMM_WB.
- IMM_WB: reg_write=1, reg_dst=00, mem_to_reg=00. Next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=010. Next MEM_RD for LW, MEM_WR for SW.
- MEM_RD: i_or_d=1, mem_read=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem_to_reg=01. Next FETCH.
- MEM_WR: i_or_d=1, mem_write=1. Holds until mem_ready, then FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01.
  - pc_write = zero for BEQ, ~zero for BNE.
  - Next FETCH.
- JUMP:
  - pc_src=10, pc_write=1.
  - JAL additionally: reg_write=1, reg_dst=10, mem_to_reg=10. The PC register holds PC+4 at this point.
  - Next FETCH.
- HALT:
  - Absorbing; only reset exits.
  - halted=1; all write enables and memory requests are 0.
- Cycle counts with mem_ready tied high:
  - R-type, ADDI, ORI, SW: 4.
  - LW: 5.
  - BEQ, BNE, J, JAL: 3.
  - Each mem_ready=0 cycle in FETCH, MEM_RD or MEM_WR adds 1.
- Guarantees:
  - mem_read and mem_write are never both 1.
  - reg_write and mem_write are never both 1.

Optional Feature:
- Macro MC_PERF_CNT_EN.
- When defined:
  - Adds output cycle_cnt[31:0]: increments every non-HALT cycle.
  - Adds output retire_cnt[31:0]: increments on every transition into FETCH from a non-reset state.
  - Both counters clear on reset and wrap modulo 2^32.
- When undefined: the ports and registers do not exist.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC_R, ALU_WB, EXEC_I, IMM_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, HALT);
  - the 3-bit ALU op codes;
  - pc_src, reg_dst, mem_to_reg and alu_src_b encodings.
- Opcode/funct constants come from the existing mips.h.
- One sub-module: alu_op_decode. Combinational mapping of funct/opcode to alu_op plus a legal flag; used by DECODE and EXEC_R.

Test Plan:
- reset held 2 cycles, then released, mem_ready=1, instr=ADD (0x01095020) -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1, reg_dst=01 in cycle 4; back in FETCH in cycle 5.
- LW 0x8D090004 with mem_ready low for 2 cycles in MEM_RD -> mem_read stays 1 and i_or_d=1 for 3 cycles; MEM_WB asserts mem_to_reg=01; 7 cycles total.
- BEQ with zero=1, then BNE with zero=1 -> pc_write=1, pc_src=01 for BEQ; pc_write=0 for BNE; each takes 3 cycles.
- JAL 0x0C100004 -> JUMP asserts pc_write=1, pc_src=10, reg_write=1, reg_dst=10, mem_to_reg=10.
- instr=0xFC000000 -> halted=1 and illegal=1 after DECODE, no further pc_write; instr=0 -> halted=1, illegal=0.
- reset asserted during MEM_WR -> mem_write=0 in the next cycle, FSM in FETCH; with MC_PERF_CNT_EN defined, cycle_cnt=0 and retire_cnt=0.
